// File: rtl/imem_dp_ctrl.sv
// Dual-port instruction memory: port A pipeline fetch with stall hold, port B byte-write loader, BOOT/RUN ownership FSM.
// Latency 1 on both ports; fetch_stall holds fetch outputs; optional IMEM_CLEAR_ON_RESET_EN zero-sweeps memory after reset.
module imem_dp_ctrl #(
    parameter int AWIDTH    = 14,
    parameter int DWIDTH    = 32,
    parameter int BOOT_SKIP = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    fetch_req,
    input  logic [AWIDTH-1:0]       fetch_addr,
    input  logic                    fetch_stall,
    output logic [DWIDTH-1:0]       fetch_data,
    output logic                    fetch_valid,
    input  logic                    ld_en,
    input  logic [AWIDTH-1:0]       ld_addr,
    input  logic [DWIDTH-1:0]       ld_din,
    input  logic [DWIDTH/8-1:0]     ld_wbe,
    input  logic                    ld_release,
    input  logic                    ld_halt,
    output logic [DWIDTH-1:0]       ld_dout,
    output logic                    ld_rvalid,
    output logic                    busy
);
    localparam int NBYTE = DWIDTH / 8;
    localparam int DEPTH = 1 << AWIDTH;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

    localparam state_t ST_POST = (BOOT_SKIP != 0) ? ST_RUN : ST_BOOT;
`ifdef IMEM_CLEAR_ON_RESET_EN
    localparam state_t ST_RST = ST_CLEAR;
`else
    localparam state_t ST_RST = ST_POST;
`endif

    logic [DWIDTH-1:0] mem [DEPTH];

    state_t            state_q, state_d;
    logic              clearing;
    logic              clr_done;
    logic              ld_wr, ld_rd;
    logic              fetch_ok;
    logic [DWIDTH-1:0] fetch_fwd;
    logic [DWIDTH-1:0] fetch_data_q, fetch_data_d;
    logic              fetch_valid_q, fetch_valid_d;
    logic [DWIDTH-1:0] ld_dout_q, ld_dout_d;
    logic              ld_rvalid_q, ld_rvalid_d;

`ifdef IMEM_CLEAR_ON_RESET_EN
    logic [AWIDTH-1:0] clr_cnt_q, clr_cnt_d;

    assign clearing  = (state_q == ST_CLEAR);
    assign clr_done  = clearing && (clr_cnt_q == {AWIDTH{1'b1}});
    assign clr_cnt_d = clearing ? clr_cnt_q + {{(AWIDTH-1){1'b0}}, 1'b1} : clr_cnt_q;

    // Counter resets asynchronously so a reset mid-sweep restarts at word 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clr_cnt_q <= '0;
        end else begin
            clr_cnt_q <= clr_cnt_d;
        end
    end
`else
    assign clearing = 1'b0;
    assign clr_done = 1'b0;
`endif

    assign ld_wr = ld_en && !clearing && (ld_wbe != '0);
    assign ld_rd = ld_en && !clearing && (ld_wbe == '0);

    // Halt takes priority over release in the same cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_BOOT:  if (ld_release && !ld_halt) state_d = ST_RUN;
            ST_RUN:   if (ld_halt) state_d = ST_BOOT;
            ST_CLEAR: if (clr_done) state_d = ST_POST;
            default:  state_d = ST_RST;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RST;
        end else begin
            state_q <= state_d;
        end
    end

    // Array has no reset so the loaded image survives rst_n.
    always_ff @(posedge clk) begin
        if (ld_wr) begin
            for (int b = 0; b < NBYTE; b++) begin
                if (ld_wbe[b]) mem[ld_addr][8*b +: 8] <= ld_din[8*b +: 8];
            end
        end
`ifdef IMEM_CLEAR_ON_RESET_EN
        if (clearing) mem[clr_cnt_q] <= '0;
`endif
    end

    // Write-first merge so a same-cycle loader write never yields a stale instruction.
    always_comb begin
        fetch_fwd = mem[fetch_addr];
        if (ld_wr && (ld_addr == fetch_addr)) begin
            for (int b = 0; b < NBYTE; b++) begin
                if (ld_wbe[b]) fetch_fwd[8*b +: 8] = ld_din[8*b +: 8];
            end
        end
    end

    // Fetch only while RUN persists across this edge; a halt edge drops valid right away.
    assign fetch_ok = (state_q == ST_RUN) && (state_d == ST_RUN);

    always_comb begin
        fetch_valid_d = fetch_valid_q;
        fetch_data_d  = fetch_data_q;
        if (!fetch_ok) begin
            fetch_valid_d = 1'b0;
        end else if (!fetch_stall) begin
            fetch_valid_d = fetch_req;
            if (fetch_req) fetch_data_d = fetch_fwd;
        end
    end

    always_comb begin
        ld_rvalid_d = ld_rd;
        ld_dout_d   = ld_dout_q;
        if (ld_rd) ld_dout_d = mem[ld_addr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_data_q  <= '0;
            fetch_valid_q <= 1'b0;
            ld_dout_q     <= '0;
            ld_rvalid_q   <= 1'b0;
        end else begin
            fetch_data_q  <= fetch_data_d;
            fetch_valid_q <= fetch_valid_d;
            ld_dout_q     <= ld_dout_d;
            ld_rvalid_q   <= ld_rvalid_d;
        end
    end

    assign fetch_data  = fetch_data_q;
    assign fetch_valid = fetch_valid_q;
    assign ld_dout     = ld_dout_q;
    assign ld_rvalid   = ld_rvalid_q;
    assign busy        = (state_q != ST_RUN);

endmodule

// File: tb/tb_imem_dp_ctrl.sv
// Randomized bench for imem_dp_ctrl against a word-array reference model; also exercises the clear sweep when IMEM_CLEAR_ON_RESET_EN is set.
module tb_imem_dp_ctrl;
`ifdef IMEM_CLEAR_ON_RESET_EN
    localparam int AW = 4;
`else
    localparam int AW = 6;
`endif
    localparam int DW    = 32;
    localparam int NB    = DW / 8;
    localparam int DEPTH = 1 << AW;

    logic          clk, rst_n;
    logic          fetch_req, fetch_stall;
    logic [AW-1:0] fetch_addr, ld_addr;
    logic [DW-1:0] fetch_data, ld_din, ld_dout;
    logic          fetch_valid, ld_en, ld_release, ld_halt, ld_rvalid, busy;
    logic [NB-1:0] ld_wbe;

    imem_dp_ctrl #(.AWIDTH(AW), .DWIDTH(DW), .BOOT_SKIP(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_stall(fetch_stall),
        .fetch_data(fetch_data), .fetch_valid(fetch_valid),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_din(ld_din), .ld_wbe(ld_wbe),
        .ld_release(ld_release), .ld_halt(ld_halt),
        .ld_dout(ld_dout), .ld_rvalid(ld_rvalid), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: memory words, ownership flag, expected registered outputs.
    logic [DW-1:0] m_mem [DEPTH];
    bit            m_run;
    logic [DW-1:0] e_fd, e_ld;
    bit            e_fv, e_lrv;
    int            n_tests, n_fail;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".fetch_valid"}, 32'(fetch_valid), 32'(e_fv));
        chk({tag, ".fetch_data"}, fetch_data, e_fd);
        chk({tag, ".ld_rvalid"}, 32'(ld_rvalid), 32'(e_lrv));
        chk({tag, ".ld_dout"}, ld_dout, e_ld);
        chk({tag, ".busy"}, 32'(busy), 32'(!m_run));
    endtask

    task automatic idle();
        fetch_req = 1'b0; fetch_stall = 1'b0; fetch_addr = '0;
        ld_en = 1'b0; ld_addr = '0; ld_din = '0; ld_wbe = '0;
        ld_release = 1'b0; ld_halt = 1'b0;
    endtask

    // Applies the current inputs for one clock and checks every output afterwards.
    task automatic cycle(input string tag);
        logic [DW-1:0] merged, n_fd, n_ld;
        bit            nrun, n_fv, n_lrv, wr;
        wr     = ld_en && (ld_wbe != 0);
        nrun   = m_run ? !ld_halt : (ld_release && !ld_halt);
        merged = m_mem[fetch_addr];
        if (wr && ld_addr == fetch_addr)
            for (int b = 0; b < NB; b++) if (ld_wbe[b]) merged[8*b +: 8] = ld_din[8*b +: 8];
        n_fv = e_fv; n_fd = e_fd;
        if (!(m_run && nrun)) n_fv = 1'b0;
        else if (!fetch_stall) begin
            n_fv = fetch_req;
            if (fetch_req) n_fd = merged;
        end
        n_lrv = ld_en && !wr;
        n_ld  = n_lrv ? m_mem[ld_addr] : e_ld;
        @(posedge clk); #1;
        if (wr) for (int b = 0; b < NB; b++) if (ld_wbe[b]) m_mem[ld_addr][8*b +: 8] = ld_din[8*b +: 8];
        e_fv = n_fv; e_fd = n_fd; e_lrv = n_lrv; e_ld = n_ld; m_run = nrun;
        check_all(tag);
    endtask

    task automatic ld_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NB-1:0] be);
        idle(); ld_en = 1'b1; ld_addr = a; ld_din = d; ld_wbe = be;
        cycle("ld_write");
        idle();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst.fetch_valid", 32'(fetch_valid), 0);
        chk("rst.fetch_data", fetch_data, 0);
        chk("rst.ld_rvalid", 32'(ld_rvalid), 0);
        chk("rst.ld_dout", ld_dout, 0);
        e_fv = 0; e_fd = '0; e_lrv = 0; e_ld = '0; m_run = 0;
        idle();
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
`ifdef IMEM_CLEAR_ON_RESET_EN
        for (int i = 0; i < DEPTH; i++) begin
            ld_en = 1'b1; ld_addr = AW'($urandom); ld_din = $urandom;
            ld_wbe = NB'($urandom); ld_release = 1'b1;
            @(posedge clk); #1;
            chk("clr.busy", 32'(busy), 1);
            chk("clr.fetch_valid", 32'(fetch_valid), 0);
            chk("clr.ld_rvalid", 32'(ld_rvalid), 0);
        end
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        idle();
`endif
    endtask

    initial begin
        n_tests = 0; n_fail = 0;
        rst_n = 1'b1;
        idle();
        #2;
        do_reset();
        chk("rst.busy", 32'(busy), 1);

`ifdef IMEM_CLEAR_ON_RESET_EN
        ld_release = 1'b1; cycle("clr_release"); idle();
        for (int a = 0; a < DEPTH; a++) begin
            fetch_req = 1'b1; fetch_addr = AW'(a);
            cycle("clr_fetch");
            chk("clr_fetch_zero", fetch_data, 0);
        end
        idle(); ld_halt = 1'b1; cycle("clr_halt"); idle();
`endif

        // Test 1: load image in BOOT, release, fetch back.
        for (int a = 0; a < DEPTH; a++) ld_write(AW'(a), $urandom, 4'hF);
        ld_write(0, 32'h00500093, 4'hF);
        ld_write(1, 32'h00A00113, 4'hF);
        ld_write(2, 32'h11223344, 4'hF);
        ld_release = 1'b1; cycle("t1_release"); idle();
        chk("t1_busy", 32'(busy), 0);
        fetch_req = 1'b1; fetch_addr = 0; cycle("t1_f0");
        chk("t1_fd0", fetch_data, 32'h00500093);
        fetch_addr = 1; cycle("t1_f1");
        chk("t1_fd1", fetch_data, 32'h00A00113);
        chk("t1_fv1", 32'(fetch_valid), 1);

        // Test 2: stall holds outputs while address moves.
        fetch_stall = 1'b1; fetch_addr = 5;
        for (int i = 0; i < 3; i++) begin
            cycle("t2_stall");
            chk("t2_fd_hold", fetch_data, 32'h00A00113);
            chk("t2_fv_hold", 32'(fetch_valid), 1);
        end

        // Test 3: same-cycle partial write forwards to fetch.
        idle();
        fetch_req = 1'b1; fetch_addr = 2;
        ld_en = 1'b1; ld_addr = 2; ld_din = 32'hAABBCCDD; ld_wbe = 4'b0011;
        cycle("t3_fwd");
        chk("t3_fd_fwd", fetch_data, 32'h1122CCDD);
        idle(); ld_en = 1'b1; ld_addr = 2; cycle("t3_rd");
        chk("t3_ld_dout", ld_dout, 32'h1122CCDD);
        chk("t3_ld_rvalid", 32'(ld_rvalid), 1);

        // Test 4: halt wins over release; fetch blocked in BOOT.
        idle(); ld_halt = 1'b1; ld_release = 1'b1; cycle("t4_halt");
        chk("t4_busy", 32'(busy), 1);
        chk("t4_fv", 32'(fetch_valid), 0);
        idle(); fetch_req = 1'b1; fetch_addr = 0; cycle("t4_boot_fetch");
        chk("t4_fv_boot", 32'(fetch_valid), 0);

        // Test 5: asynchronous reset mid-run keeps memory contents.
        idle(); ld_release = 1'b1; cycle("t5_release");
        idle(); fetch_req = 1'b1; fetch_addr = 1; ld_en = 1'b1; ld_addr = 0;
        cycle("t5_busy_outputs");
        do_reset();
        ld_release = 1'b1; cycle("t5_release2");
        idle(); fetch_req = 1'b1; fetch_addr = 0; cycle("t5_fetch");
`ifdef IMEM_CLEAR_ON_RESET_EN
        chk("t5_retained", fetch_data, 32'h0);
`else
        chk("t5_retained", fetch_data, 32'h00500093);
`endif

        // Random traffic: forwarding collisions, stalls, halts and releases.
        for (int i = 0; i < 600; i++) begin
            fetch_req   = ($urandom_range(3) != 0);
            fetch_addr  = AW'($urandom);
            fetch_stall = ($urandom_range(4) == 0);
            ld_en       = ($urandom_range(2) == 0);
            ld_addr     = ($urandom_range(1) == 0) ? fetch_addr : AW'($urandom);
            ld_din      = $urandom;
            ld_wbe      = ($urandom_range(2) == 0) ? '0 : NB'($urandom);
            ld_release  = ($urandom_range(9) == 0);
            ld_halt     = ($urandom_range(29) == 0);
            cycle("rand");
        end
        idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/imem_dp_ctrl.md
Name: imem_dp_ctrl

Overview:
- Parametrised successor to the fixed 16K x 32 dual-port instruction memory.
- Generalised in width and depth, with byte-write loader port B and fetch port A.
- Adds a fetch req/valid handshake with stall hold, same-cycle write-to-fetch forwarding, and a BOOT/RUN ownership state machine.
- Sits in the IF stage: port A feeds the pipeline; port B is driven by the UART/debug program loader.

Parameters:
- AWIDTH, 14, word-address width; depth = 2^AWIDTH words.
- DWIDTH, 32, data width; must be a multiple of 8; NBYTE = DWIDTH/8.
- BOOT_SKIP, 0, if 1 reset exits directly to RUN (image preloaded from file).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- fetch_req  in  1  fetch request.
- fetch_addr  in  AWIDTH  fetch word address.
- fetch_stall  in  1  pipeline stall; holds fetch outputs.
- fetch_data  out  DWIDTH  fetched instruction.
- fetch_valid  out  1  fetch_data valid.
- ld_en  in  1  loader access strobe.
- ld_addr  in  AWIDTH  loader word address.
- ld_din  in  DWIDTH  loader write data.
- ld_wbe  in  NBYTE  byte write enables; all-zero means read.
- ld_release  in  1  pulse: BOOT -> RUN.
- ld_halt  in  1  pulse: RUN -> BOOT.
- ld_dout  out  DWIDTH  loader read data.
- ld_rvalid  out  1  ld_dout valid.
- busy  out  1  high whenever state != RUN.

Behaviour:
- Reset: asynchronous, active-low; the only clock is clk.
- Reset values: fetch_data=0, fetch_valid=0, ld_dout=0, ld_rvalid=0.
- Reset state: BOOT, or RUN if BOOT_SKIP=1 (CLEAR if the optional feature is compiled in; see below).
- Memory array is not reset; contents survive rst_n assertion mid-operation. Outputs clear immediately on rst_n low.
- States: BOOT (loader owns memory, fetch blocked) and RUN. Transitions evaluated on clk edge:
  - BOOT & ld_release -> RUN.
  - RUN & ld_halt -> BOOT.
  - ld_halt & ld_release in the same cycle: halt wins (RUN -> BOOT, BOOT stays BOOT).
  - ld_release in RUN and ld_halt in BOOT are ignored.
- Fetch (port A), synchronous read, latency 1:
  - In RUN with fetch_stall=0: next cycle fetch_data=mem[fetch_addr] and fetch_valid=fetch_req.
  - fetch_stall=1: fetch_data and fetch_valid hold their values; fetch_req and fetch_addr are ignored that cycle.
  - fetch_req=0 and no stall: fetch_valid=0 next cycle; fetch_data holds its last value.
  - In BOOT: fetch_valid=0 next cycle regardless of fetch_req/stall. The RUN->BOOT edge drops fetch_valid on the following cycle.
- Loader (port B), allowed in BOOT and RUN:
  - ld_en & ld_wbe!=0: byte lanes i with ld_wbe[i]=1 are written at the clk edge; ld_rvalid=0 next cycle.
  - ld_en & ld_wbe==0: read; next cycle ld_dout=mem[ld_addr], ld_rvalid=1.
  - ld_en=0: ld_rvalid=0 next cycle; ld_dout holds.
- Forwarding: a loader write and an accepted fetch to the same address in the same cycle return new data on fetch_data. Per byte: lanes with ld_wbe set take ld_din, other lanes take old memory. This is write-first behaviour; no stale instruction is delivered.
- Address wrap: addresses are exactly AWIDTH bits, with no out-of-range case.

Optional Feature:
- Macro: IMEM_CLEAR_ON_RESET_EN.
- Defined:
  - Reset enters state CLEAR. An AWIDTH-bit counter writes 0 to every word, one word per cycle: 2^AWIDTH cycles, address 0 upward.
  - busy=1 throughout; fetch_valid=0; ld_en, ld_release and ld_halt are ignored; ld_rvalid=0.
  - After the last word is written: CLEAR -> BOOT, or CLEAR -> RUN if BOOT_SKIP=1.
  - rst_n asserted mid-clear restarts the sweep at address 0.
- Undefined: no CLEAR state and no counter; reset goes straight to BOOT/RUN and memory is left uncleared.

Test Plan:
1. Reset, BOOT: write 0x00500093 to addr 0 and 0x00A00113 to addr 1 with ld_wbe=4'hF; pulse ld_release; fetch_req with addr 0 then 1 -> fetch_data=0x00500093 then 0x00A00113, fetch_valid=1 one cycle after each request.
2. RUN: fetch addr 1 with fetch_stall=1 held for 3 cycles while fetch_addr changes to 5 -> fetch_data stays 0x00A00113 and fetch_valid stays 1 for all 3 cycles.
3. Same cycle: fetch addr 2 (mem=0x11223344) and loader write 0xAABBCCDD with ld_wbe=4'b0011 -> fetch_data=0x1122CCDD; a later loader read of addr 2 -> ld_dout=0x1122CCDD, ld_rvalid=1.
4. RUN: ld_halt and ld_release together -> busy=1 next cycle, fetch_valid=0; a fetch_req in BOOT -> fetch_valid stays 0.
5. Mid-run: drop rst_n asynchronously -> fetch_valid, ld_rvalid, fetch_data and ld_dout go 0 before the next edge; after release and ld_release, fetch addr 0 -> 0x00500093 (contents retained).
6. With IMEM_CLEAR_ON_RESET_EN and AWIDTH=4:
   - busy=1 for 16 cycles after reset; ld_en writes during the sweep are ignored.
   - After ld_release, fetches of addr 0..15 all return 0.
